// File: rtl/instr_reg_gen.sv
// instr_reg_gen: assembles an instruction word from BEATS memory beats, MSB
// beat first, and presents it to the controller through a valid/ready stage.
// Optional build macro INSTR_REG_PAUSE_EN: when defined, a cycle with ena low
// only pauses assembly; when undefined, it discards a partially built word.
module instr_reg_gen #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned BEATS  = 2,
   parameter int unsigned OPC_W  = 3
) (
   input  logic                                        clk1,
   input  logic                                        rst,
   input  logic                                        ena,
   input  logic [DATA_W-1:0]                           data,
   output logic                                        in_ready,
   output logic                                        beat_ack,
   output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] beat_idx,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [DATA_W*BEATS-1:0]                     opc_iraddr,
   output logic [OPC_W-1:0]                            opcode,
   output logic [DATA_W*BEATS-OPC_W-1:0]               ir_addr
);

   localparam int unsigned WORD_W = DATA_W * BEATS;
   localparam int unsigned ADDR_W = WORD_W - OPC_W;
   localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [WORD_W-1:0] collector;
   logic [WORD_W-1:0] word_c;
   logic              last_c;
   logic              accept_c;
   logic              discard_c;

   // Final beat is the only one that can be stalled by a full output stage
   assign last_c   = (beat_idx == IDX_W'(BEATS - 1));
   assign in_ready = !(last_c && out_valid && !out_ready);
   assign accept_c = ena && in_ready;

`ifdef INSTR_REG_PAUSE_EN
   assign discard_c = 1'b0;
`else
   assign discard_c = !ena && (beat_idx != '0);
`endif

   // Completed word: earlier beats from the collector, final beat straight from the bus
   always_comb begin
      word_c               = collector;
      word_c[DATA_W-1:0]   = data;
   end

   assign opcode  = opc_iraddr[WORD_W-1 -: OPC_W];
   assign ir_addr = opc_iraddr[ADDR_W-1:0];

   // Collector: each accepted beat lands in its slot, MSB beat first
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         collector <= '0;
      end else if (accept_c) begin
         for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_idx == IDX_W'(k)) begin
               collector[WORD_W-1-k*DATA_W -: DATA_W] <= data;
            end
         end
      end
   end

   // Beat index: advance on accept, wrap after the final beat, clear on discard
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         beat_idx <= '0;
      end else if (accept_c) begin
         if (last_c) begin
            beat_idx <= '0;
         end else begin
            beat_idx <= beat_idx + IDX_W'(1);
         end
      end else if (discard_c) begin
         beat_idx <= '0;
      end
   end

   // One-cycle acknowledge after every accepted beat
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         beat_ack <= 1'b0;
      end else begin
         beat_ack <= accept_c;
      end
   end

   // Output stage: load on completion (even while popping), otherwise clear on pop
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         opc_iraddr <= '0;
         out_valid  <= 1'b0;
      end else if (accept_c && last_c) begin
         opc_iraddr <= word_c;
         out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_reg_gen.sv
// Bench for instr_reg_gen: table-driven vectors on the default configuration,
// scoreboard of completed words, plus hand sequences for reset and other
// parameter sets.
module tb_instr_reg_gen;

   logic        clk1 = 1'b0;
   logic        rst;
   logic        ena;
   logic [7:0]  data;
   logic        out_ready;
   logic        in_ready;
   logic        beat_ack;
   logic [0:0]  beat_idx;
   logic        out_valid;
   logic [15:0] opc_iraddr;
   logic [2:0]  opcode;
   logic [12:0] ir_addr;

   logic        ena4;
   logic [3:0]  data4;
   logic        ordy4;
   logic        in_ready4;
   logic        beat_ack4;
   logic [1:0]  beat_idx4;
   logic        out_valid4;
   logic [15:0] opc4;
   logic [3:0]  opcode4;
   logic [11:0] ir_addr4;

   logic        ena1;
   logic [15:0] data1;
   logic        ordy1;
   logic        in_ready1;
   logic        beat_ack1;
   logic [0:0]  beat_idx1;
   logic        out_valid1;
   logic [15:0] opc1;
   logic [2:0]  opcode1;
   logic [12:0] ir_addr1;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb[$];

   typedef struct {
      logic        ena;
      logic [7:0]  data;
      logic        rdy;
      logic        push;
      logic        exp_rdy;
      logic        exp_ack;
      logic        exp_idx;
      logic        exp_valid;
      logic [15:0] exp_word;
   } vec_t;

   vec_t tbl[14];

   always #5 clk1 = ~clk1;

   instr_reg_gen dut (
      .clk1(clk1), .rst(rst), .ena(ena), .data(data), .in_ready(in_ready),
      .beat_ack(beat_ack), .beat_idx(beat_idx), .out_valid(out_valid),
      .out_ready(out_ready), .opc_iraddr(opc_iraddr), .opcode(opcode),
      .ir_addr(ir_addr)
   );

   instr_reg_gen #(.DATA_W(4), .BEATS(4), .OPC_W(4)) dut4 (
      .clk1(clk1), .rst(rst), .ena(ena4), .data(data4), .in_ready(in_ready4),
      .beat_ack(beat_ack4), .beat_idx(beat_idx4), .out_valid(out_valid4),
      .out_ready(ordy4), .opc_iraddr(opc4), .opcode(opcode4),
      .ir_addr(ir_addr4)
   );

   instr_reg_gen #(.DATA_W(16), .BEATS(1), .OPC_W(3)) dut1 (
      .clk1(clk1), .rst(rst), .ena(ena1), .data(data1), .in_ready(in_ready1),
      .beat_ack(beat_ack1), .beat_idx(beat_idx1), .out_valid(out_valid1),
      .out_ready(ordy1), .opc_iraddr(opc1), .opcode(opcode1),
      .ir_addr(ir_addr1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic e, input logic [7:0] d, input logic r,
                               input logic p, input logic xr, input logic xa,
                               input logic xi, input logic xv, input logic [15:0] xw);
      vec_t v;
      v.ena = e; v.data = d; v.rdy = r; v.push = p; v.exp_rdy = xr;
      v.exp_ack = xa; v.exp_idx = xi; v.exp_valid = xv; v.exp_word = xw;
      return v;
   endfunction

   // Drive one vector just after a rising edge, check in_ready, then registered outputs
   task automatic step(input vec_t v, input string tag);
      ena = v.ena; data = v.data; out_ready = v.rdy;
      if (v.push) sb.push_back(v.exp_word);
      #1;
      chk({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
      @(posedge clk1); #1;
      chk({tag, " beat_ack"}, 32'(beat_ack), 32'(v.exp_ack));
      chk({tag, " beat_idx"}, 32'(beat_idx), 32'(v.exp_idx));
      chk({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_valid));
      chk({tag, " opc_iraddr"}, 32'(opc_iraddr), 32'(v.exp_word));
      chk({tag, " opcode"}, 32'(opcode), 32'(v.exp_word[15:13]));
      chk({tag, " ir_addr"}, 32'(ir_addr), 32'(v.exp_word[12:0]));
   endtask

   // Reset pulse placed between rising edges; leaves the bench aligned at edge+1
   task automatic rst_pulse(input logic do_check);
      ena = 1'b0; data = '0;
      #2 rst = 1'b1;
      #1;
      if (do_check) begin
         chk("async rst in_ready", 32'(in_ready), 32'd1);
         chk("async rst beat_idx", 32'(beat_idx), 32'd0);
         chk("async rst beat_ack", 32'(beat_ack), 32'd0);
         chk("async rst out_valid", 32'(out_valid), 32'd0);
         chk("async rst opc_iraddr", 32'(opc_iraddr), 32'd0);
      end
      #1 rst = 1'b0;
      @(posedge clk1); #1;
   endtask

   // Scoreboard: a pop happens at the next edge whenever valid and ready are both high
   always @(negedge clk1) begin
      if (!rst && out_valid && out_ready) begin
         chk("sb has entry", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) chk("sb word", 32'(opc_iraddr), 32'(sb.pop_front()));
      end
   end

   initial begin
      tbl[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      tbl[1]  = mk(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA53C);
      tbl[2]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA53C);
      tbl[3]  = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA53C);
      tbl[4]  = mk(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1122);
      tbl[5]  = mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1122);
      tbl[6]  = mk(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1122);
      tbl[7]  = mk(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h3344);
      tbl[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3344);
      tbl[9]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h3344);
`ifdef INSTR_REG_PAUSE_EN
      tbl[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3344);
      tbl[11] = mk(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFF01);
      tbl[12] = mk(1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFF01);
      tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFF01);
`else
      tbl[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3344);
      tbl[11] = mk(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h3344);
      tbl[12] = mk(1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0102);
      tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0102);
`endif

      rst = 1'b1; ena = 1'b0; data = '0; out_ready = 1'b0;
      ena4 = 1'b0; data4 = '0; ordy4 = 1'b1;
      ena1 = 1'b0; data1 = '0; ordy1 = 1'b1;
      repeat (2) @(posedge clk1);
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset beat_idx", 32'(beat_idx), 32'd0);
      chk("reset beat_ack", 32'(beat_ack), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset opc_iraddr", 32'(opc_iraddr), 32'd0);
      rst = 1'b0;
      @(posedge clk1); #1;

      for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("vec%0d", i));

      // Reset mid-word discards the partial beat, then a fresh word assembles
      rst_pulse(1'b0);
      step(mk(1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000), "rst 7E");
      rst_pulse(1'b1);
      step(mk(1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000), "rst 12");
      step(mk(1'b1, 8'h34, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234), "rst 34");
      step(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234), "rst idle");

      // Four nibble beats with opcode as wide as a beat
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("w4 beat_idx%0d", i), 32'(beat_idx4), 32'(i));
         ena4 = 1'b1;
         data4 = 4'(4'hA + i);
         @(posedge clk1); #1;
      end
      ena4 = 1'b0;
      chk("w4 beat_idx wrap", 32'(beat_idx4), 32'd0);
      chk("w4 out_valid", 32'(out_valid4), 32'd1);
      chk("w4 opc_iraddr", 32'(opc4), 32'hABCD);
      chk("w4 opcode", 32'(opcode4), 32'hA);
      chk("w4 ir_addr", 32'(ir_addr4), 32'hBCD);
      @(posedge clk1); #1;
      chk("w4 popped", 32'(out_valid4), 32'd0);

      // Single-beat words stream back to back with no bubble
      ena1 = 1'b1; data1 = 16'h0001;
      @(posedge clk1); #1;
      chk("b1 valid first", 32'(out_valid1), 32'd1);
      chk("b1 word first", 32'(opc1), 32'h0001);
      chk("b1 beat_idx", 32'(beat_idx1), 32'd0);
      data1 = 16'h0002;
      @(posedge clk1); #1;
      chk("b1 valid second", 32'(out_valid1), 32'd1);
      chk("b1 word second", 32'(opc1), 32'h0002);
      chk("b1 ack", 32'(beat_ack1), 32'd1);
      ena1 = 1'b0;
      @(posedge clk1); #1;
      chk("b1 drained", 32'(out_valid1), 32'd0);
      chk("b1 word kept", 32'(opc1), 32'h0002);

      chk("sb drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
